m_plot_receiver: RTL and testbench
==================================

Name: m_plot_receiver

Overview:
- Receiving end of the pixel-plot stream that the circle drawer produces.
- Samples (x, y, plot) strobes plus a colour and range-checks each pixel. Accepted pixels are buffered in a small FIFO and written into a 160x120 framebuffer write port using the linear address y*WIDTH+x.
- Handles memory backpressure and reports overflow, dropped-pixel counts and end-of-figure completion.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64
- COLOUR_W, 3, colour bits per pixel
- WIDTH, 160, framebuffer columns
- HEIGHT, 120, framebuffer rows
- ADDR_W, 15, framebuffer address width; must cover WIDTH*HEIGHT-1 = 19199

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  asynchronous active-low reset
- x  in  8  pixel column from drawer
- y  in  7  pixel row from drawer
- colour  in  COLOUR_W  pixel colour
- plot  in  1  one-cycle strobe: x/y/colour valid
- src_done  in  1  drawer finished; level or pulse, sampled every cycle
- mem_ready  in  1  framebuffer accepts a write this cycle
- mem_addr  out  ADDR_W  write address
- mem_data  out  COLOUR_W  write data
- mem_we  out  1  write valid; held until mem_ready
- full  out  1  FIFO full
- overflow  out  1  sticky: a pixel was lost because the FIFO was full
- drop_cnt  out  8  out-of-range pixels discarded, saturating at 255
- wr_cnt  out  16  pixels written to memory, wrapping
- done  out  1  one-cycle pulse at completion

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, full=0, mem_we=0, mem_addr=0, mem_data=0, overflow=0, drop_cnt=0, wr_cnt=0, done=0, FSM=IDLE. Reset mid-operation discards all pending pixels.
- Input stage, every cycle with plot=1:
  - x>=WIDTH or y>=HEIGHT: pixel discarded; drop_cnt increments unless it is already 255.
  - In range and full=0 at the sampling edge: {addr, colour} pushed.
  - In range and full=1: pixel lost and overflow set. A pop in the same cycle does not free a slot for this push.
  - plot=0: x, y and colour are ignored.
- Address: computed combinationally at push as (y<<7)+(y<<5)+x, zero-extended to ADDR_W and stored in the FIFO. This arithmetic is valid only for WIDTH=160; other widths use a y*WIDTH multiply.
- Output register (mem_addr, mem_data, mem_we):
  - Slot is free when mem_we=0, or when mem_we=1 and mem_ready=1.
  - When the slot is free and the FIFO is not empty, pop into the slot and set mem_we=1.
  - When the slot is free and the FIFO is empty, clear mem_we to 0.
  - While mem_we=1 and mem_ready=0, mem_addr and mem_data hold stable.
  - With mem_ready held high, one write per cycle is sustained.
- wr_cnt increments on each cycle with mem_we & mem_ready.
- Latency: a plot arriving at edge N into an empty FIFO gives mem_we=1 after edge N+1, visible during cycle N+1→N+2.
- full = (count==DEPTH). A simultaneous push and pop while not full leaves count unchanged. A pop from an empty FIFO never occurs.
- FSM:
  - IDLE→RUN on the first plot, or on src_done.
  - RUN→DRAIN when src_done=1.
  - DRAIN→DONE when the FIFO is empty and mem_we=0, or mem_we & mem_ready with the FIFO empty.
  - DONE: done=1 for one cycle, then IDLE. Counters are kept until reset.
  - plot arriving during DRAIN is still accepted.
  - src_done while already in DRAIN or DONE is ignored.
- overflow is cleared only by reset.

Test Plan:
- Single pixel: x=20, y=10, colour=6, mem_ready=1 → mem_we high for one cycle, mem_addr=1620, mem_data=6, wr_cnt=1.
- Corner addresses: (0,0)→0; (159,119)→19199; (160,5) and (3,120) → no write, drop_cnt=2.
- Backpressure: mem_ready=0, then 10 back-to-back plots with DEPTH=8 → full after 8 pushes (the 9th is held in the output register only if it was popped earlier). Exactly the lost plots set overflow=1. Release mem_ready → writes emerge in order with unchanged addresses; wr_cnt = accepted pixel count.
- Completion: 5 plots followed by src_done pulse, mem_ready toggling 1/0 → done pulses exactly once, one cycle after the 5th write handshake; wr_cnt=5.
- Reset mid-stream: 4 pixels queued with mem_ready=0, assert rst=0 asynchronously between edges → mem_we, full and counters are 0 immediately; after release no stale writes appear.
- Full circle: drive captured drawer output for centre (80,60), radius 20 → 8-way symmetric pixel set written; e.g. (100,60)→9700 and (80,40)→6480 are present; drop_cnt=0.

Source files
------------

// File: rtl/m_plot_receiver.sv
// Plot-stream receiver: range-checks drawer pixels, queues them and
// writes them into a 160x120 framebuffer port with backpressure.
module m_plot_receiver #(
  parameter int DEPTH    = 8,
  parameter int COLOUR_W = 3,
  parameter int WIDTH    = 160,
  parameter int HEIGHT   = 120,
  parameter int ADDR_W   = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          x,
  input  logic [6:0]          y,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                plot,
  input  logic                src_done,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [COLOUR_W-1:0] mem_data,
  output logic                mem_we,
  output logic                full,
  output logic                overflow,
  output logic [7:0]          drop_cnt,
  output logic [15:0]         wr_cnt,
  output logic                done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [COLOUR_W-1:0] colour;
  } pix_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_t;

  pix_t          fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  state_t        state;

  logic              in_range;
  logic              push;
  logic              pop;
  logic              empty;
  logic              slot_free;
  logic [ADDR_W-1:0] pix_addr;

  assign in_range  = ({1'b0, x} < 9'(WIDTH))
                  && ({1'b0, y} < 8'(HEIGHT));
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign slot_free = ~mem_we | mem_ready;
  assign push      = plot & in_range & ~full;
  assign pop       = slot_free & ~empty;

  // 160 = 128 + 32, so the row offset is two shifts and an add
  generate
    if (WIDTH == 160) begin : g_shift
      assign pix_addr = (ADDR_W'(y) << 7)
                      + (ADDR_W'(y) << 5)
                      + ADDR_W'(x);
    end else begin : g_mul
      assign pix_addr = ADDR_W'(y) * ADDR_W'(WIDTH)
                      + ADDR_W'(x);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr] <= '{addr: pix_addr, colour: colour};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      wr_cnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (pop) begin
        mem_we   <= 1'b1;
        mem_addr <= fifo_q[rd_ptr].addr;
        mem_data <= fifo_q[rd_ptr].colour;
      end else if (slot_free) begin
        mem_we <= 1'b0;
      end
      if (plot && in_range && full) overflow <= 1'b1;
      if (plot && !in_range && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
      if (mem_we && mem_ready) wr_cnt <= wr_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE:  if (plot || src_done) state <= RUN;
        RUN:   if (src_done) state <= DRAIN;
        DRAIN: if (empty && slot_free) begin
          state <= FIN;
          done  <= 1'b1;
        end
        FIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_plot_receiver.sv
// Directed bench for m_plot_receiver: scoreboard of expected writes
// checked against the framebuffer handshake.
module tb_m_plot_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  x = '0;
  logic [6:0]  y = '0;
  logic [2:0]  colour = '0;
  logic        plot = 1'b0;
  logic        src_done = 1'b0;
  logic        mem_ready = 1'b0;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we;
  logic        full;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic [15:0] wr_cnt;
  logic        done;

  m_plot_receiver dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .colour(colour),
    .plot(plot), .src_done(src_done), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .full(full), .overflow(overflow), .drop_cnt(drop_cnt),
    .wr_cnt(wr_cnt), .done(done)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_hs = 0;
  bit          toggle = 1'b0;
  bit          seen_a = 1'b0;
  bit          seen_b = 1'b0;
  bit          hold_v = 1'b0;
  logic [17:0] hold_val;
  logic [17:0] sb_e;
  logic [17:0] exp_q [$];

  always @(posedge clk) cyc++;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && mem_we) chk("hold_stable", {mem_addr, mem_data}, hold_val);
      hold_v   = mem_we && !mem_ready;
      hold_val = {mem_addr, mem_data};
      if (mem_we && mem_ready) begin
        last_hs = cyc + 1;
        if (mem_addr == 15'd9700) seen_a = 1'b1;
        if (mem_addr == 15'd6480) seen_b = 1'b1;
        chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          sb_e = exp_q.pop_front();
          chk("write", {mem_addr, mem_data}, sb_e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (toggle) mem_ready = ~mem_ready;
  endtask

  task automatic px(int xi, int yi, int c, bit acc);
    x      = 8'(xi);
    y      = 7'(yi);
    colour = 3'(c);
    plot   = 1'b1;
    if (acc) exp_q.push_back({15'(yi * 160 + xi), 3'(c)});
    step();
    plot = 1'b0;
  endtask

  task automatic wait_drain(int budget, string tag);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !mem_we) break;
      step();
    end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    int done_n;
    int done_cyc;
    int npts;
    int cx, cy, px_, py_, d;

    #1 rst = 1'b0;
    #3;
    chk("rst_we", mem_we, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_wr", wr_cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // single pixel and latency
    mem_ready = 1'b1;
    px(20, 10, 6, 1);
    chk("lat_edge_n", mem_we, 0);
    step();
    chk("lat_we", mem_we, 1);
    chk("lat_addr", mem_addr, 1620);
    chk("lat_data", mem_data, 6);
    step();
    chk("one_cycle_we", mem_we, 0);
    chk("wr_single", wr_cnt, 1);

    // corners and out-of-range
    px(0, 0, 1, 1);
    px(159, 119, 2, 1);
    px(160, 5, 3, 0);
    px(3, 120, 4, 0);
    wait_drain(30, "drain_corner");
    chk("drop_corner", drop_cnt, 2);
    chk("wr_corner", wr_cnt, 3);

    // backpressure: one in the output slot, eight queued, tenth lost
    mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      px(10 + i, 20 + i, i, i < 9);
      if (i == 8) begin
        chk("bp_full9", full, 1);
        chk("bp_ovf9", overflow, 0);
      end
    end
    chk("bp_ovf10", overflow, 1);
    chk("bp_full10", full, 1);
    repeat (3) step();
    mem_ready = 1'b1;
    wait_drain(40, "drain_bp");
    chk("bp_wr", wr_cnt, 12);
    chk("bp_full_clr", full, 0);
    chk("bp_ovf_sticky", overflow, 1);

    // completion with toggling ready
    step();
    #2 rst = 1'b0;
    #1 rst = 1'b1;
    step();
    chk("rst2_wr", wr_cnt, 0);
    chk("rst2_ovf", overflow, 0);
    toggle = 1'b1;
    for (int i = 0; i < 5; i++) px(30 + i, 40, i + 1, 1);
    src_done = 1'b1;
    step();
    src_done = 1'b0;
    done_n   = 0;
    done_cyc = -1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
    end
    toggle    = 1'b0;
    mem_ready = 1'b1;
    chk("done_once", done_n, 1);
    chk("done_timing", done_cyc, last_hs);
    chk("done_wr", wr_cnt, 5);
    chk("done_sb", exp_q.size(), 0);

    // asynchronous reset mid-stream
    mem_ready = 1'b0;
    px(200, 0, 0, 0);
    for (int i = 0; i < 4; i++) px(50 + i, 70, i, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_we", mem_we, 0);
    chk("mid_full", full, 0);
    chk("mid_wr", wr_cnt, 0);
    chk("mid_drop", drop_cnt, 0);
    exp_q.delete();
    rst = 1'b1;
    mem_ready = 1'b1;
    repeat (20) step();
    chk("mid_no_stale", wr_cnt, 0);

    // full circle, centre (80,60) radius 20
    seen_a = 1'b0;
    seen_b = 1'b0;
    npts = 0;
    cx = 80;
    cy = 60;
    px_ = 0;
    py_ = 20;
    d = 1 - 20;
    while (px_ <= py_) begin
      px(cx + px_, cy + py_, 1, 1);
      px(cx - px_, cy + py_, 2, 1);
      px(cx + px_, cy - py_, 3, 1);
      px(cx - px_, cy - py_, 4, 1);
      px(cx + py_, cy + px_, 5, 1);
      px(cx - py_, cy + px_, 6, 1);
      px(cx + py_, cy - px_, 7, 1);
      px(cx - py_, cy - px_, 0, 1);
      npts += 8;
      px_++;
      if (d < 0) begin
        d += 2 * px_ + 1;
      end else begin
        py_--;
        d += 2 * (px_ - py_) + 1;
      end
    end
    wait_drain(500, "drain_circle");
    chk("circle_9700", seen_a, 1);
    chk("circle_6480", seen_b, 1);
    chk("circle_drop", drop_cnt, 0);
    chk("circle_ovf", overflow, 0);
    chk("circle_wr", wr_cnt, npts);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
